// File: rtl/inv_sub_bytes_engine.sv
// Column-serial AES InvSubBytes engine: one 32-bit column per BUSY cycle, valid/ready on both sides.
// Define INV_SUB_BYTES_WIDE_EN to substitute all 16 bytes in a single BUSY cycle instead.
module inv_sub_bytes_engine (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         in_valid,
    input  logic [127:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [127:0] out_data,
    input  logic         out_ready,
    output logic         busy
);

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [1:0]   col_q, col_d;
    logic [127:0] data_q, data_d;

    // Four parallel lookups covering one column of the state.
    function automatic logic [31:0] invSub4(input logic [31:0] w);
        logic [31:0] r;
        r = {INV_SBOX[w[31:24]], INV_SBOX[w[23:16]], INV_SBOX[w[15:8]], INV_SBOX[w[7:0]]};
        return r;
    endfunction

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            col_q   <= 2'd0;
            data_q  <= 128'h0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    col_d   = 2'd0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
`ifdef INV_SUB_BYTES_WIDE_EN
                data_d  = {invSub4(data_q[127:96]), invSub4(data_q[95:64]),
                           invSub4(data_q[63:32]),  invSub4(data_q[31:0])};
                col_d   = 2'd0;
                state_d = DONE;
`else
                // Columns above col_q stay raw, so out_data shows the partial result.
                case (col_q)
                    2'd0:    data_d[31:0]   = invSub4(data_q[31:0]);
                    2'd1:    data_d[63:32]  = invSub4(data_q[63:32]);
                    2'd2:    data_d[95:64]  = invSub4(data_q[95:64]);
                    default: data_d[127:96] = invSub4(data_q[127:96]);
                endcase
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = data_q;

endmodule

// File: tb/tb_inv_sub_bytes_engine.sv
// Scoreboard bench for inv_sub_bytes_engine; the reference inverse S-box is derived from GF(2^8)
// arithmetic. Define INV_SUB_BYTES_WIDE_EN here too when the design is built in wide mode.
module tb_inv_sub_bytes_engine;

`ifdef INV_SUB_BYTES_WIDE_EN
    localparam int LAT   = 1;
    localparam int STEPS = 1;
`else
    localparam int LAT   = 4;
    localparam int STEPS = 4;
`endif

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         in_valid = 1'b0;
    logic [127:0] in_data = '0;
    logic         out_ready = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic [127:0] out_data;
    logic         busy;

    int           total = 0;
    int           bad = 0;
    int           edgeCount = 0;
    int           acceptEdge = 0;
    logic         prevValid = 1'b0;
    logic [127:0] sbQ[$];
    logic [7:0]   invTable[256];

    inv_sub_bytes_engine dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edgeCount <= edgeCount + 1;

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        logic       hi;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            hi = aa[7];
            aa = aa << 1;
            if (hi) aa = aa ^ 8'h1b;
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    // Forward S-box = affine(GF inverse); the inverse table is filled by reversing it.
    task automatic buildModel();
        logic [7:0] x8, inv, s;
        for (int x = 0; x < 256; x++) begin
            x8  = 8'(x);
            inv = 8'h00;
            if (x != 0) begin
                for (int y = 1; y < 256; y++) begin
                    if (gmul(x8, 8'(y)) == 8'h01) inv = 8'(y);
                end
            end
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            invTable[s] = x8;
        end
    endtask

    function automatic logic [127:0] partial(input logic [127:0] d, input int cols);
        logic [127:0] r;
        logic [7:0]   b;
        r = d;
        for (int i = 0; i < 4 * cols; i++) begin
            b = 8'(d >> (8 * i));
            r = (r & ~(128'hFF << (8 * i))) | (128'(invTable[b]) << (8 * i));
        end
        return r;
    endfunction

    function automatic logic [127:0] randState();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds in_valid until an edge accepts the state; in_valid is left high for back-to-back use.
    task automatic applyStimulus(input logic [127:0] data, input logic [127:0] exp, output int accEdge);
        in_valid = 1'b1;
        in_data  = data;
        accEdge  = -1;
        for (int i = 0; i < 30; i++) begin
            if (in_ready) begin
                accEdge    = edgeCount + 1;
                acceptEdge = accEdge;
                sbQ.push_back(exp);
                tick();
                break;
            end
            tick();
        end
        if (accEdge < 0) checkOutput("acceptTimeout", 128'(in_ready), 128'd1);
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (sbQ.size() == 0) break;
            tick();
        end
        if (sbQ.size() != 0) begin
            checkOutput("drainTimeout", 128'(sbQ.size()), 128'd0);
            sbQ.delete();
        end
    endtask

    task automatic waitValid(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (out_valid) break;
            tick();
        end
        if (!out_valid) checkOutput("validTimeout", 128'(out_valid), 128'd1);
    endtask

    always @(negedge clk) begin
        if (!n_rst) begin
            prevValid <= 1'b0;
        end else begin
            if (out_valid && !prevValid) checkOutput("latency", 128'(edgeCount - acceptEdge), 128'(LAT));
            if (out_valid && out_ready) begin
                if (sbQ.size() == 0) checkOutput("sbUnexpected", 128'(out_valid), 128'd0);
                else checkOutput("sbData", out_data, sbQ.pop_front());
            end
            prevValid <= out_valid;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int           acc;
        int           accs[3];
        logic [127:0] d;
        logic         sawValid;

        buildModel();

        repeat (3) tick();
        checkOutput("rstInReady", 128'(in_ready), 128'd1);
        checkOutput("rstOutValid", 128'(out_valid), 128'd0);
        checkOutput("rstBusy", 128'(busy), 128'd0);
        checkOutput("rstOutData", out_data, 128'h0);
        n_rst = 1'b1;
        tick();

        out_ready = 1'b1;
        applyStimulus({16{8'h63}}, 128'h0, acc);
        in_valid = 1'b0;
        drain(20);

        applyStimulus(128'h7C7C7C7C_7C7C7C7C_7C7C7C7C_16EDFF00,
                      128'h01010101_01010101_01010101_FF537D52, acc);
        in_valid = 1'b0;
        drain(20);

        for (int rep = 0; rep < 2; rep++) begin
            d = randState();
            out_ready = 1'b0;
            applyStimulus(d, partial(d, 4), acc);
            in_valid = 1'b0;
            checkOutput("loadRaw", out_data, d);
            checkOutput("busyHigh", 128'(busy), 128'd1);
            for (int k = 1; k <= STEPS; k++) begin
                tick();
                checkOutput($sformatf("colStep%0d", k), out_data, partial(d, (STEPS == 1) ? 4 : k));
            end
            checkOutput("colDoneValid", 128'(out_valid), 128'd1);
            out_ready = 1'b1;
            drain(20);
        end

        out_ready = 1'b0;
        d = randState();
        applyStimulus(d, partial(d, 4), acc);
        in_valid = 1'b0;
        waitValid(10);
        in_valid = 1'b1;
        in_data  = ~d;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("holdValid", 128'(out_valid), 128'd1);
            checkOutput("holdInReady", 128'(in_ready), 128'd0);
            checkOutput("holdData", out_data, partial(d, 4));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain(10);
        tick();
        tick();
        checkOutput("noCapture", 128'(out_valid), 128'd0);
        checkOutput("idleAfterHold", 128'(in_ready), 128'd1);

        out_ready = 1'b0;
        d = randState();
        applyStimulus(d, partial(d, 4), acc);
        in_valid = 1'b0;
        tick();
        tick();
        n_rst = 1'b0;
        #1;
        checkOutput("midRstData", out_data, 128'h0);
        checkOutput("midRstInReady", 128'(in_ready), 128'd1);
        checkOutput("midRstBusy", 128'(busy), 128'd0);
        checkOutput("midRstValid", 128'(out_valid), 128'd0);
        sbQ.delete();
        out_ready = 1'b1;
        tick();
        n_rst = 1'b1;
        sawValid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) sawValid = 1'b1;
        end
        checkOutput("noValidAfterRst", 128'(sawValid), 128'd0);

        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d = randState();
            applyStimulus(d, partial(d, 4), accs[i]);
        end
        in_valid = 1'b0;
        checkOutput("spacing01", 128'(accs[1] - accs[0]), 128'(LAT + 2));
        checkOutput("spacing12", 128'(accs[2] - accs[1]), 128'(LAT + 2));
        drain(40);

        // Sweep every byte value through the table once.
        for (int j = 0; j < 16; j++) begin
            for (int i = 0; i < 16; i++) begin
                d = (d & ~(128'hFF << (8 * i))) | (128'(16 * j + i) << (8 * i));
            end
            applyStimulus(d, partial(d, 4), acc);
        end
        in_valid = 1'b0;
        drain(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inv_sub_bytes_engine.md
INV_SUB_BYTES_ENGINE -- requirements
Module: inv_sub_bytes_engine

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk and n_rst.
REQ-002 The block SHALL have no parameters.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 n_rst  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  in_data holds a 128-bit state to be inverse-substituted.
REQ-006 in_data  input  128  cipher state; byte i = in_data[8i+7:8i], i=0..15.
REQ-007 in_ready  output  1  block can accept a state this cycle.
REQ-008 out_valid  output  1  out_data holds a complete result.
REQ-009 out_data  output  128  working/result register; byte i = out_data[8i+7:8i].
REQ-010 out_ready  input  1  consumer accepts out_data.
REQ-011 busy  output  1  high while the state is BUSY or DONE.

Function
REQ-012 The block SHALL compute InvSubBytes (FIPS-197 inverse S-box) per byte: out byte i = InvS(in byte i), byte order identical to the forward SubBytes layer.
REQ-013 The inverse S-box SHALL be an internal 256-entry constant table; it SHALL NOT instantiate the forward S-box.
REQ-014 The FSM SHALL have states IDLE, BUSY and DONE; reset state is IDLE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; busy = (state != IDLE).
REQ-016 In IDLE, on a rising edge with in_valid=1, the block SHALL load in_data into out_data, clear the 2-bit column counter col to 0, and go to BUSY; with in_valid=0 it SHALL stay in IDLE and hold out_data.
REQ-017 In BUSY, each rising edge SHALL replace bytes 4*col..4*col+3 of out_data with their InvS values using four parallel lookups, and SHALL increment col.
REQ-018 The edge that processes col=3 SHALL move the FSM to DONE; col SHALL wrap to 0.
REQ-019 Latency: out_valid SHALL rise exactly 4 clock edges after the accept edge; throughput is one state per 6 cycles when out_ready is held at 1.
REQ-020 In DONE, out_data SHALL be stable; on an edge with out_ready=1 the FSM SHALL return to IDLE, otherwise it SHALL hold DONE indefinitely.
REQ-021 in_valid SHALL be ignored outside IDLE; a state presented while busy SHALL NOT be captured and SHALL NOT corrupt out_data.
REQ-022 In BUSY, out_data SHALL show the partially substituted state: columns below col are substituted, the rest are raw.
REQ-023 out_ready SHALL be ignored outside DONE.

Reset
REQ-024 While n_rst=0, regardless of clk, the block SHALL force state=IDLE, col=0, out_data=128'h0, out_valid=0, busy=0, in_ready=1.
REQ-025 Reset asserted mid-BUSY or mid-DONE SHALL abandon the operation; after release the block SHALL not emit a result until a new state is accepted.

Configuration
REQ-026 Macro INV_SUB_BYTES_WIDE_EN: when defined, BUSY SHALL substitute all 16 bytes on its first edge using 16 lookups and go to DONE, making out_valid rise 1 edge after the accept edge; when undefined, the 4-column behaviour of REQ-017..REQ-019 SHALL apply.
REQ-027 In wide mode, col SHALL remain 0, and all handshake, reset and DONE-hold behaviour SHALL be unchanged.

Verification
REQ-028 in_data = all bytes 8'h63, in_valid pulsed, out_ready=1 -> out_valid high 4 edges after accept (1 edge if WIDE), out_data = 128'h0.
REQ-029 in_data byte0=8'h00, byte1=8'hFF, byte2=8'hED, byte3=8'h16, rest 8'h7C -> out bytes 0..3 = 8'h52, 8'h7D, 8'h53, 8'hFF, rest 8'h01.
REQ-030 out_ready held 0 for 10 cycles in DONE -> out_valid stays 1, out_data stable, in_ready stays 0; a different in_data presented meanwhile is not captured.
REQ-031 n_rst pulsed low after two BUSY edges -> out_data=0, in_ready=1, and no out_valid after release until a new accept.
REQ-032 Check after each BUSY edge -> exactly the 4 bytes of the current column change, and col advances 0,1,2,3.
REQ-033 Back-to-back: 3 states with in_valid and out_ready held at 1 -> three results in order, accepts spaced 6 cycles apart.
